// File: rtl/nor2_bist_if.sv
// Signal bundle between the NOR2 BIST sequencer and its surroundings.
// The slave side is the BIST block; the master side is the wrapper that
// requests runs, reads results and carries the cell's Y response back.
interface nor2_bist_if;
    logic       START;
    logic       A;
    logic       B;
    logic       Y;
    logic       BUSY;
    logic       DONE;
    logic       FAIL;
    logic [1:0] ERR_VEC;
    logic [7:0] ERR_CNT;

    modport master (
        output START,
        output Y,
        input  A,
        input  B,
        input  BUSY,
        input  DONE,
        input  FAIL,
        input  ERR_VEC,
        input  ERR_CNT
    );

    modport slave (
        input  START,
        input  Y,
        output A,
        output B,
        output BUSY,
        output DONE,
        output FAIL,
        output ERR_VEC,
        output ERR_CNT
    );
endinterface

// File: rtl/nor2_bist.sv
// Built-in self-test sequencer and response checker for a 2-input NOR cell.
// Drives {A,B} through 00,01,11,10 for PASSES sweeps, holds each vector for
// SETTLE_CYCLES+1 cycles and compares Y with ~(A|B) at the end of the hold.
// Optional build macro NOR2_BIST_STOP_ON_FAIL_EN: the first mismatch ends
// the run; otherwise every vector of every pass is applied and counted.
module nor2_bist #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned PASSES        = 1
) (
    input  logic        CLK,
    input  logic        RST,
    nor2_bist_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);
    localparam logic [7:0] PASS_LAST   = 8'(PASSES - 1);

    state_t     state_q, state_d;
    logic [3:0] settle_q, settle_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] pass_q, pass_d;
    logic [1:0] ab_q, ab_d;
    logic       done_q, done_d;
    logic       fail_q, fail_d;
    logic [1:0] ev_q, ev_d;
    logic [7:0] ec_q, ec_d;

    logic       sample;
    logic       mismatch;
    logic       last_vec;
    logic       stop_run;
    logic [1:0] next_idx;

    // Vector index to {A,B} in Gray order: 0->00, 1->01, 2->11, 3->10.
    function automatic logic [1:0] gray(input logic [1:0] i);
        return {i[1], i[1] ^ i[0]};
    endfunction

    // State, counters and result registers; RST clears everything mid-run.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            settle_q <= '0;
            idx_q    <= '0;
            pass_q   <= '0;
            ab_q     <= '0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
            ev_q     <= '0;
            ec_q     <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            idx_q    <= idx_d;
            pass_q   <= pass_d;
            ab_q     <= ab_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
            ev_q     <= ev_d;
            ec_q     <= ec_d;
        end
    end

    // Next-state: sequence vectors, check Y at end of each hold, record errors.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        idx_d    = idx_q;
        pass_d   = pass_q;
        ab_d     = ab_q;
        done_d   = done_q;
        fail_d   = fail_q;
        ev_d     = ev_q;
        ec_d     = ec_q;

        sample   = (state_q == RUN) && (settle_q == SETTLE_LAST);
        // X/Z on Y never equals the expected 0/1, so it counts as a mismatch.
        mismatch = sample && (bus.Y !== ~(ab_q[1] | ab_q[0]));
        last_vec = (idx_q == 2'd3) && (pass_q == PASS_LAST);
        next_idx = idx_q + 2'd1;
`ifdef NOR2_BIST_STOP_ON_FAIL_EN
        stop_run = mismatch;
`else
        stop_run = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    state_d  = RUN;
                    settle_d = '0;
                    idx_d    = '0;
                    pass_d   = '0;
                    ab_d     = gray(2'd0);
                    done_d   = 1'b0;
                    fail_d   = 1'b0;
                    ev_d     = '0;
                    ec_d     = '0;
                end
            end
            RUN: begin
                if (mismatch) begin
                    if (ec_q != '1) begin
                        ec_d = ec_q + 8'd1;
                    end
                    if (!fail_q) begin
                        fail_d = 1'b1;
                        ev_d   = ab_q;
                    end
                end
                if (sample) begin
                    settle_d = '0;
                    if (last_vec || stop_run) begin
                        state_d = FIN;
                        ab_d    = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = next_idx;
                        ab_d  = gray(next_idx);
                        if (idx_q == 2'd3) begin
                            pass_d = pass_q + 8'd1;
                        end
                    end
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.A       = ab_q[1];
    assign bus.B       = ab_q[0];
    assign bus.BUSY    = (state_q == RUN);
    assign bus.DONE    = done_q;
    assign bus.FAIL    = fail_q;
    assign bus.ERR_VEC = ev_q;
    assign bus.ERR_CNT = ec_q;

endmodule

// File: tb/tb_nor2_bist.sv
// Testbench for nor2_bist: three instances with different SETTLE_CYCLES /
// PASSES settings, each driving a NOR cell model with a per-vector fault mask.
module tb_nor2_bist;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nor2_bist_if i0 ();
    nor2_bist_if i1 ();
    nor2_bist_if i2 ();

    // Cell model: ideal NOR, with output inverted for vectors whose mask bit is set.
    logic [3:0] flip [3];
    assign i0.Y = ~(i0.A | i0.B) ^ flip[0][{i0.A, i0.B}];
    assign i1.Y = ~(i1.A | i1.B) ^ flip[1][{i1.A, i1.B}];
    assign i2.Y = ~(i2.A | i2.B) ^ flip[2][{i2.A, i2.B}];

    nor2_bist #(.SETTLE_CYCLES(2), .PASSES(1)) u0 (.CLK(clk), .RST(rst), .bus(i0));
    nor2_bist #(.SETTLE_CYCLES(2), .PASSES(2)) u1 (.CLK(clk), .RST(rst), .bus(i1));
    nor2_bist #(.SETTLE_CYCLES(0), .PASSES(1)) u2 (.CLK(clk), .RST(rst), .bus(i2));

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed view: [14:13]={A,B} [12]=BUSY [11]=DONE [10]=FAIL [9:8]=ERR_VEC [7:0]=ERR_CNT
    function automatic logic [14:0] outs(input int d);
        case (d)
            0:       return {i0.A, i0.B, i0.BUSY, i0.DONE, i0.FAIL, i0.ERR_VEC, i0.ERR_CNT};
            1:       return {i1.A, i1.B, i1.BUSY, i1.DONE, i1.FAIL, i1.ERR_VEC, i1.ERR_CNT};
            default: return {i2.A, i2.B, i2.BUSY, i2.DONE, i2.FAIL, i2.ERR_VEC, i2.ERR_CNT};
        endcase
    endfunction

    task automatic set_start(input int d, input logic v);
        case (d)
            0:       i0.START = v;
            1:       i1.START = v;
            default: i2.START = v;
        endcase
    endtask

    task automatic params(input int d, output int s, output int p);
        case (d)
            0:       begin s = 2; p = 1; end
            1:       begin s = 2; p = 2; end
            default: begin s = 0; p = 1; end
        endcase
    endtask

    // Reference: walk the Gray sweep, a vector fails when its mask bit is set.
    task automatic model(input int s, input int p, input logic [3:0] mask,
                         output int busy, output logic fl,
                         output logic [1:0] ev, output logic [7:0] ec);
        logic [1:0] g [4];
        int cnt;
        int n;
        bit stopped;
        g = '{2'b00, 2'b01, 2'b11, 2'b10};
        cnt = 0; n = 0; stopped = 0; ev = 2'b00;
        for (int pi = 0; pi < p; pi++) begin
            for (int v = 0; v < 4; v++) begin
                if (!stopped) begin
                    n++;
                    if (mask[g[v]]) begin
                        if (cnt == 0) ev = g[v];
                        cnt++;
`ifdef NOR2_BIST_STOP_ON_FAIL_EN
                        stopped = 1;
`endif
                    end
                end
            end
        end
        busy = n * (s + 1);
        fl   = (cnt > 0);
        ec   = (cnt > 255) ? 8'd255 : 8'(cnt);
    endtask

    // One run on instance d; optional START re-pulse before busy-cycle restart_at.
    task automatic run(input int d, input logic [3:0] mask, input int restart_at);
        int s, p, busy_exp, c;
        logic fl_exp;
        logic [1:0] ev_exp;
        logic [7:0] ec_exp;
        logic [14:0] o;
        logic [1:0] g [4];
        g = '{2'b00, 2'b01, 2'b11, 2'b10};
        params(d, s, p);
        model(s, p, mask, busy_exp, fl_exp, ev_exp, ec_exp);
        flip[d] = mask;
        @(negedge clk);
        set_start(d, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(d, 1'b0);
        o = outs(d);
        check($sformatf("done_clr d%0d", d), 32'(o[11]), 32'd0);
        c = 0;
        for (int t = 0; t < 2000; t++) begin
            o = outs(d);
            if (!o[12]) break;
            check($sformatf("ab d%0d c%0d", d, c), 32'(o[14:13]), 32'(g[(c / (s + 1)) % 4]));
            c++;
            if (restart_at == c) set_start(d, 1'b1);
            @(negedge clk);
            set_start(d, 1'b0);
        end
        o = outs(d);
        check($sformatf("busy_len d%0d", d), 32'(c), 32'(busy_exp));
        check($sformatf("done d%0d", d), 32'(o[11]), 32'd1);
        check($sformatf("ab_fin d%0d", d), 32'(o[14:13]), 32'd0);
        check($sformatf("fail_flag d%0d", d), 32'(o[10]), 32'(fl_exp));
        check($sformatf("err_vec d%0d", d), 32'(o[9:8]), 32'(ev_exp));
        check($sformatf("err_cnt d%0d", d), 32'(o[7:0]), 32'(ec_exp));
        @(negedge clk);
        o = outs(d);
        check($sformatf("idle_hold d%0d", d), 32'(o[12:0]),
              32'({1'b0, 1'b1, fl_exp, ev_exp, ec_exp}));
        if (restart_at > 0) begin
            repeat (3) @(negedge clk);
            o = outs(d);
            check($sformatf("no_restart d%0d", d), 32'(o[12:11]), 32'b01);
        end
    endtask

    initial begin
        logic [14:0] o;
        rst = 1'b1;
        i0.START = 1'b0; i1.START = 1'b0; i2.START = 1'b0;
        flip[0] = '0; flip[1] = '0; flip[2] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            o = outs(d);
            check($sformatf("reset d%0d", d), 32'(o), 32'd0);
        end
        rst = 1'b0;

        // Directed cases: ideal cell, stuck-at-0, stuck-at-1 (two passes / no settle).
        run(0, 4'b0000, 0);
        run(0, 4'b0001, 0);
        run(1, 4'b1110, 0);
        run(2, 4'b1110, 0);
        // START at edge k+4 of a 4-cycle run must be ignored.
        run(2, 4'b0000, 4);

        // Reset mid-run at edge k+5, after a mismatch has been recorded.
        flip[0] = 4'b0001;
        @(negedge clk);
        set_start(0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(0, 1'b0);
        repeat (3) @(negedge clk);
        o = outs(0);
        check("pre_rst_fail_flag", 32'(o[10]), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        o = outs(0);
        check("mid_run_reset", 32'(o), 32'd0);
        @(negedge clk);
        o = outs(0);
        check("post_rst_idle", 32'(o), 32'd0);
        run(0, 4'b0000, 0);

        // START held high re-triggers on the first IDLE cycle.
        flip[2] = '0;
        @(negedge clk);
        set_start(2, 1'b1);
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        o = outs(2);
        check("held_idle", 32'(o[12:11]), 32'b01);
        @(posedge clk);
        @(negedge clk);
        o = outs(2);
        check("held_retrigger", 32'(o[12:11]), 32'b10);
        set_start(2, 1'b0);
        repeat (8) @(negedge clk);

        // Random fault masks on random instances.
        for (int r = 0; r < 12; r++) begin
            int d;
            logic [3:0] m;
            d = int'($urandom_range(0, 2));
            m = 4'($urandom_range(0, 15));
            run(d, m, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nor2_bist.md
# nor2_bist

Built-in self-test sequencer and response checker for a two-input NOR cell of the gp12t3v3 library. It drives the cell's A/B inputs through all four input vectors in Gray order and samples the cell's Y output after a programmable settle time. It compares Y against the expected NOR value and reports pass/fail, the first failing vector and an error count. It sits on the driving side of the cell under test, in characterization and silicon-test wrappers.

## Interface
Parameters:
- SETTLE_CYCLES, 2: extra cycles each vector is held before Y is sampled; legal range 0..15.
- PASSES, 1: number of full 4-vector sweeps per run; legal range 1..255.

Ports:
- CLK  input  1  rising-edge clock; the only clock in the block.
- RST  input  1  synchronous, active-high reset.
- START  input  1  run request; sampled only in IDLE.
- A  output  1  stimulus to cell input A; registered.
- B  output  1  stimulus to cell input B; registered.
- Y  input  1  response from cell output Y; combinational from A/B, no synchronizer.
- BUSY  output  1  run in progress.
- DONE  output  1  run finished; level, held until next START or RST.
- FAIL  output  1  at least one mismatch in the last run; held with DONE.
- ERR_VEC  output  2  {A,B} of the first failing vector.
- ERR_CNT  output  8  mismatch count, saturating at 255.

## Operation
- States: IDLE, RUN, FIN.
- IDLE:
  - A=B=0, BUSY=0.
  - START=1 moves the block to RUN, clears DONE, FAIL, ERR_VEC and ERR_CNT, and loads vector 0.
- RUN:
  - Vector order {A,B}: 00, 01, 11, 10, then repeat for each pass. Only one input changes per step.
  - Each vector is held for SETTLE_CYCLES+1 cycles. Y is compared on the final cycle of the hold.
  - Expected Y = ~(A|B). A Y value of X or Z counts as a mismatch.
  - On a mismatch:
    - ERR_CNT increments, saturating at 255.
    - On the first mismatch of the run, FAIL is set and ERR_VEC takes the current {A,B}.
  - After the last vector of the last pass the block moves to FIN.
- FIN:
  - DONE=1, BUSY=0, A=B=0 for one cycle, then back to IDLE.
  - DONE, FAIL, ERR_VEC and ERR_CNT hold their values in IDLE.
- START while BUSY=1 is ignored.
- START held high continuously re-triggers a new run on the first IDLE cycle.
- Counters:
  - 4-bit settle counter.
  - 2-bit vector index; wraps from 3 to 0 and increments the pass counter.
  - 8-bit pass counter.

## Timing
- Reset values: A=0, B=0, BUSY=0, DONE=0, FAIL=0, ERR_VEC=2'b00, ERR_CNT=0; state IDLE.
- RST takes priority over everything, including mid-run. All outputs return to reset values at the next edge; no partial result is kept.
- START=1 at edge k:
  - BUSY=1 and {A,B}=00 after edge k.
  - BUSY stays high for exactly PASSES*4*(SETTLE_CYCLES+1) cycles.
  - Default parameters: the last sample is at edge k+12; DONE=1 and BUSY=0 after edge k+12.
- Y is sampled at the edge that ends each vector's hold. The cell's path delay must be under one CLK period when SETTLE_CYCLES=0.
- A and B change only on CLK edges, in Gray order.
- Results (FAIL, ERR_VEC, ERR_CNT) are valid whenever DONE=1.

## Configuration
- Macro: NOR2_BIST_STOP_ON_FAIL_EN.
- Defined: the first mismatch ends the run.
  - The block moves to FIN on the next edge with ERR_CNT=1, FAIL=1 and ERR_VEC set.
  - The remaining vectors and passes are skipped.
- Undefined: the run always completes every vector of every pass and counts all mismatches.

## Test plan
- Ideal NOR model on Y, defaults, START pulse at edge k → DONE=1 after edge k+12; FAIL=0; ERR_CNT=0; A/B sequence 00,01,11,10, each vector held 3 cycles.
- Y stuck at 0, defaults → FAIL=1, ERR_VEC=00, ERR_CNT=1.
- Y stuck at 1, PASSES=2, macro undefined → FAIL=1, ERR_VEC=01, ERR_CNT=6, BUSY high for 24 cycles.
- Y stuck at 1, macro defined → run ends after the vector-01 sample; ERR_CNT=1, ERR_VEC=01, DONE=1 after edge k+6.
- RST=1 at edge k+5 of a run → next cycle all outputs at reset values, state IDLE; a new START gives a correct full run.
- START pulsed at edge k+4 during a run, SETTLE_CYCLES=0 → ignored; DONE after edge k+4 of the original run only, no restart.
